// File: rtl/adc_cfg_pkg.sv
// adc_cfg_pkg: shared types and constants for the ADC configuration controller.
// Holds the FSM encoding, serial frame layout and the power-up init register table.
package adc_cfg_pkg;

  typedef enum logic [2:0] {
    POR_WAIT,
    INIT,
    SHIFT,
    GAP,
    CAL_PULSE,
    CAL_WAIT,
    IDLE
  } state_t;

  localparam int          FRAME_W      = 32;
  localparam logic [11:0] FRAME_HEADER = 12'h001;

  // Init table, entry 0 is written first.
  localparam int INIT_ENTRIES = 3;
  localparam int INIT_IW      = $clog2(INIT_ENTRIES);
  localparam logic [INIT_ENTRIES-1:0][3:0]  INIT_ADDR = {4'h3, 4'h2, 4'h1};
  localparam logic [INIT_ENTRIES-1:0][15:0] INIT_DATA = {16'h8000, 16'h007F, 16'hB2FF};

  // Build a serial frame: header, register address, register value (MSB first on the wire).
  function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] addr, input logic [15:0] data);
    return {FRAME_HEADER, addr, data};
  endfunction

endpackage

// File: rtl/adc_serial_shifter.sv
// adc_serial_shifter: 3-wire serial frame generator.
// A start pulse while idle (SCS high) loads the frame; SCS drops with bit 31 already on
// SDATA, each bit is SCLK_DIV cycles low then SCLK_DIV cycles high, SDATA only changes on
// the falling SCLK edge, and SCS returns high in the cycle SCLK goes low after bit 0.
// done pulses for one cycle together with the SCS rise.
module adc_serial_shifter
  import adc_cfg_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               sclk,
  output logic               sdata,
  output logic               scs,
  output logic               done
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [DW-1:0]      div_cnt;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;

  // Divider, bit counter and shift register; all pin outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      scs     <= 1'b1;
      done    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      done <= 1'b0;
      if (scs) begin
        if (start) begin
          scs     <= 1'b0;
          sclk    <= 1'b0;
          sdata   <= frame[FRAME_W-1];
          shreg   <= frame << 1;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
      end else if (div_cnt == DW'(SCLK_DIV - 1)) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          if (bit_cnt == 5'(FRAME_W - 1)) begin
            scs   <= 1'b1;
            sdata <= 1'b0;
            done  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            sdata   <= shreg[FRAME_W-1];
            shreg   <= shreg << 1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_cfg_ctrl.sv
// adc_cfg_ctrl: ADC serial configuration and calibration sequencer.
// After reset: power-up wait, init table writes, one calibration, then ready.
// Afterwards serves host register writes (cfg_req) and calibrations (cal_req).
// Optional macro ADC_CFG_SHADOW_EN adds a 16x16 shadow copy of written registers
// readable through shadow_addr/shadow_data.
module adc_cfg_ctrl
  import adc_cfg_pkg::*;
#(
  parameter int SCLK_DIV         = 4,
  parameter int POR_CYCLES       = 4000,
  parameter int GAP_CYCLES       = 8,       // minimum 2: cfg_ack is raised one cycle ahead
  parameter int CAL_PULSE_CYCLES = 40,
  parameter int CAL_TIMEOUT      = 1048576, // minimum 2: cal_ack is raised one cycle ahead
  parameter int NUM_INIT         = INIT_ENTRIES
) (
  input  logic        USER_CLK,
  input  logic        USER_RESET_N,
  input  logic        cfg_req,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        cfg_ack,
  input  logic        cal_req,
  output logic        cal_ack,
  output logic        busy,
  output logic        ready,
  output logic        cal_timeout,
  output logic        ADC_SCLK,
  output logic        ADC_SDATA,
  output logic        ADC_SCS,
  output logic        ADC_RUN_CALIB,
  input  logic        ADC_CALIB
`ifdef ADC_CFG_SHADOW_EN
  ,
  input  logic [3:0]  shadow_addr,
  output logic [15:0] shadow_data
`endif
);

  state_t               state, state_n;
  logic [31:0]          cnt;
  logic [INIT_IW-1:0]   idx;
  logic                 calib_s1, calib_s2;
  logic                 seen_hi, cal_end, cal_ok, cal_trig;
  logic                 start, sh_done;
  logic [FRAME_W-1:0]   frame_n;

  adc_serial_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk   (USER_CLK),
    .rst_n (USER_RESET_N),
    .start (start),
    .frame (frame_n),
    .sclk  (ADC_SCLK),
    .sdata (ADC_SDATA),
    .scs   (ADC_SCS),
    .done  (sh_done)
  );

  // Calibration complete once the ADC's busy flag has been seen high and is low again.
  // The decision is taken one cycle before leaving CAL_WAIT so cal_ack lands in the last
  // CAL_WAIT cycle and a still-held cal_req is not re-accepted in the same cycle.
  assign cal_ok   = seen_hi && !calib_s2;
  assign cal_trig = (state == CAL_WAIT) && !cal_end && (cal_ok || cnt == 32'(CAL_TIMEOUT - 2));

  // Two-flop synchroniser for the asynchronous ADC_CALIB pin.
  always_ff @(posedge USER_CLK or negedge USER_RESET_N) begin
    if (!USER_RESET_N) begin
      calib_s1 <= 1'b0;
      calib_s2 <= 1'b0;
    end else begin
      calib_s1 <= ADC_CALIB;
      calib_s2 <= calib_s1;
    end
  end

  // State register.
  always_ff @(posedge USER_CLK or negedge USER_RESET_N) begin
    if (!USER_RESET_N) state <= POR_WAIT;
    else               state <= state_n;
  end

  // Next-state logic; a frame is launched on the transition into SHIFT.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    frame_n = '0;
    case (state)
      POR_WAIT:  if (cnt == 32'(POR_CYCLES - 1)) state_n = INIT;
      INIT: begin
        frame_n = make_frame(INIT_ADDR[idx], INIT_DATA[idx]);
        start   = 1'b1;
        state_n = SHIFT;
      end
      SHIFT:     if (sh_done) state_n = GAP;
      GAP: begin
        if (cnt == 32'(GAP_CYCLES - 1)) begin
          if (ready)                        state_n = IDLE;
          else if (int'(idx) + 1 < NUM_INIT) state_n = INIT;
          else                              state_n = CAL_PULSE;
        end
      end
      CAL_PULSE: if (cnt == 32'(CAL_PULSE_CYCLES - 1)) state_n = CAL_WAIT;
      CAL_WAIT:  if (cal_end) state_n = IDLE;
      IDLE: begin
        if (cfg_req) begin
          frame_n = make_frame(cfg_addr, cfg_data);
          start   = 1'b1;
          state_n = SHIFT;
        end else if (cal_req) begin
          state_n = CAL_PULSE;
        end
      end
      default:   state_n = POR_WAIT;
    endcase
  end

  // Phase counter, init index, calibration tracking and registered status outputs.
  always_ff @(posedge USER_CLK or negedge USER_RESET_N) begin
    if (!USER_RESET_N) begin
      cnt           <= '0;
      idx           <= '0;
      seen_hi       <= 1'b0;
      cal_end       <= 1'b0;
      busy          <= 1'b1;
      ready         <= 1'b0;
      cal_timeout   <= 1'b0;
      cfg_ack       <= 1'b0;
      cal_ack       <= 1'b0;
      ADC_RUN_CALIB <= 1'b0;
    end else begin
      cnt           <= (state_n != state) ? '0 : cnt + 32'd1;
      busy          <= (state_n != IDLE);
      ADC_RUN_CALIB <= (state_n == CAL_PULSE);
      seen_hi       <= (state == CAL_WAIT) && (seen_hi || calib_s2);
      cal_end       <= (state == CAL_WAIT) && (cal_end || cal_trig);
      cfg_ack       <= ready && (state == GAP) && (cnt == 32'(GAP_CYCLES - 2));
      cal_ack       <= ready && cal_trig;
      if (state == GAP && state_n == INIT) idx <= idx + 1'b1;
      if (cal_trig) cal_timeout <= !cal_ok;
      if (state == CAL_WAIT && cal_end) ready <= 1'b1;
    end
  end

`ifdef ADC_CFG_SHADOW_EN
  logic [19:0]       wr_q;
  logic [15:0][15:0] shadow;

  // Shadow copy of every completed frame, read back with one cycle of latency.
  always_ff @(posedge USER_CLK or negedge USER_RESET_N) begin
    if (!USER_RESET_N) begin
      wr_q        <= '0;
      shadow      <= '0;
      shadow_data <= '0;
    end else begin
      if (start) wr_q <= frame_n[19:0];
      if (state == SHIFT && sh_done) shadow[wr_q[19:16]] <= wr_q[15:0];
      shadow_data <= shadow[shadow_addr];
    end
  end
`endif

endmodule

// File: tb/tb_adc_cfg_ctrl.sv
// tb_adc_cfg_ctrl: directed scoreboard bench for adc_cfg_ctrl.
// Expected frames are queued by the stimulus; a decoder process rebuilds each serial
// frame from the pins and checks it against the queue head.
module tb_adc_cfg_ctrl;
  localparam int POR  = 100;
  localparam int TMO  = 3000;
  localparam int DIV  = 4;
  localparam int CALW = 40;

  logic        USER_CLK = 1'b0;
  logic        USER_RESET_N = 1'b1;
  logic        cfg_req = 1'b0, cal_req = 1'b0, ADC_CALIB = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_ack, cal_ack, busy, ready, cal_timeout;
  logic        ADC_SCLK, ADC_SDATA, ADC_SCS, ADC_RUN_CALIB;
`ifdef ADC_CFG_SHADOW_EN
  logic [3:0]  shadow_addr = '0;
  logic [15:0] shadow_data;
`endif

  int          vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  bit          model_en = 1'b1;
  int          n_cal_pulses = 0;
  logic [31:0] sh = '0;
  int          nbits = 0, nlow = 0;
  bit          in_fr = 1'b0, psclk = 1'b0;

  always #5 USER_CLK = ~USER_CLK;

  adc_cfg_ctrl #(
    .SCLK_DIV(DIV), .POR_CYCLES(POR), .GAP_CYCLES(8), .CAL_PULSE_CYCLES(CALW),
    .CAL_TIMEOUT(TMO), .NUM_INIT(3)
  ) dut (
    .USER_CLK(USER_CLK), .USER_RESET_N(USER_RESET_N),
    .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .cal_req(cal_req), .cal_ack(cal_ack), .busy(busy), .ready(ready), .cal_timeout(cal_timeout),
    .ADC_SCLK(ADC_SCLK), .ADC_SDATA(ADC_SDATA), .ADC_SCS(ADC_SCS),
    .ADC_RUN_CALIB(ADC_RUN_CALIB), .ADC_CALIB(ADC_CALIB)
`ifdef ADC_CFG_SHADOW_EN
    , .shadow_addr(shadow_addr), .shadow_data(shadow_data)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // sel: 0 ready, 1 cfg_ack, 2 cal_ack, 3 RUN_CALIB high, 4 RUN_CALIB low
  task automatic wait_for(input int sel, input int maxc, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < maxc && !hit; i++) begin
      @(negedge USER_CLK);
      case (sel)
        0:       hit = ready;
        1:       hit = cfg_ack;
        2:       hit = cal_ack;
        3:       hit = ADC_RUN_CALIB;
        default: hit = !ADC_RUN_CALIB;
      endcase
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no event within %0d cycles", nm, maxc);
    end
  endtask

  task automatic push_init();
    exp_q.push_back(32'h0011B2FF);
    exp_q.push_back(32'h0012007F);
    exp_q.push_back(32'h00138000);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d, input string nm);
    exp_q.push_back({12'h001, a, d});
    @(posedge USER_CLK); #1;
    cfg_addr = a; cfg_data = d; cfg_req = 1'b1;
    repeat (2) @(posedge USER_CLK); #1;
    cfg_addr = ~a; cfg_data = ~d;   // must be ignored: latched at acceptance
    wait_for(1, 2000, nm);
    cfg_req = 1'b0;
  endtask

  // ADC model: reports calibration busy for 200 cycles after each RUN_CALIB pulse.
  initial forever begin
    @(negedge ADC_RUN_CALIB);
    if (model_en && USER_RESET_N) begin
      repeat (3) @(posedge USER_CLK);
      ADC_CALIB = 1'b1;
      repeat (200) @(posedge USER_CLK);
      ADC_CALIB = 1'b0;
    end
  end

  // Frame decoder and scoreboard check.
  initial forever begin
    @(negedge USER_CLK);
    if (!USER_RESET_N) begin
      in_fr = 1'b0;
    end else if (!ADC_SCS) begin
      if (!in_fr) begin in_fr = 1'b1; nbits = 0; nlow = 0; psclk = 1'b0; end
      nlow++;
      if (ADC_SCLK && !psclk) begin sh = {sh[30:0], ADC_SDATA}; nbits++; end
      psclk = ADC_SCLK;
    end else if (in_fr) begin
      in_fr = 1'b0;
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_frame: got %08h with nothing queued", sh);
      end else begin
        chk("frame", sh, exp_q.pop_front());
      end
      chk("scs_low_cycles", nlow, 64 * DIV);
      chk("frame_bits", nbits, 32);
      chk("sdata_idle", ADC_SDATA, 1'b0);
    end
  end

  // Pulse-width monitor for acks and RUN_CALIB.
  initial begin
    int wcfg = 0, wcal = 0, wrun = 0;
    forever begin
      @(negedge USER_CLK);
      if (cfg_ack) wcfg++;
      else if (wcfg != 0) begin chk("cfg_ack_width", wcfg, 1); wcfg = 0; end
      if (cal_ack) wcal++;
      else if (wcal != 0) begin chk("cal_ack_width", wcal, 1); wcal = 0; end
      if (ADC_RUN_CALIB) wrun++;
      else if (wrun != 0) begin chk("run_calib_width", wrun, CALW); wrun = 0; n_cal_pulses++; end
    end
  end

  initial begin
    int n, ncal0;
    push_init();
    #1 USER_RESET_N = 1'b0;
    #11;
    chk("rst_scs", ADC_SCS, 1'b1);
    chk("rst_sclk", ADC_SCLK, 1'b0);
    chk("rst_sdata", ADC_SDATA, 1'b0);
    chk("rst_run_calib", ADC_RUN_CALIB, 1'b0);
    chk("rst_acks", {cfg_ack, cal_ack}, 2'b00);
    chk("rst_ready", ready, 1'b0);
    chk("rst_cal_timeout", cal_timeout, 1'b0);
    chk("rst_busy", busy, 1'b1);
    @(posedge USER_CLK); #1 USER_RESET_N = 1'b1;

    // init sequence
    wait_for(0, 10000, "init_ready");
    chk("init_cal_timeout", cal_timeout, 1'b0);
    chk("init_busy", busy, 1'b0);
    chk("init_frames_left", exp_q.size(), 0);

    // single host write
    host_write(4'hA, 16'h1234, "host_cfg_ack");
    repeat (3) @(negedge USER_CLK);
    chk("host_busy_idle", busy, 1'b0);
    chk("host_frames_left", exp_q.size(), 0);

    // cfg_req and cal_req together: write first, then calibration
    ncal0 = n_cal_pulses;
    exp_q.push_back(32'h00155AA5);
    @(posedge USER_CLK); #1;
    cfg_addr = 4'h5; cfg_data = 16'h5AA5; cfg_req = 1'b1; cal_req = 1'b1;
    wait_for(1, 2000, "both_cfg_ack");
    cfg_req = 1'b0;
    chk("both_no_cal_before_ack", n_cal_pulses - ncal0, 0);
    chk("both_frames_left", exp_q.size(), 0);
    wait_for(2, 2000, "both_cal_ack");
    cal_req = 1'b0;
    chk("both_cal_after_cfg", n_cal_pulses - ncal0, 1);
    chk("both_cal_timeout", cal_timeout, 1'b0);

    // calibration timeout
    model_en = 1'b0;
    @(posedge USER_CLK); #1 cal_req = 1'b1;
    wait_for(3, 50, "tmo_run_rise");
    wait_for(4, 100, "tmo_run_fall");
    n = 1;
    while (!cal_ack && n < TMO + 50) begin @(negedge USER_CLK); n++; end
    cal_req = 1'b0;
    chk("tmo_wait_cycles", n, TMO);
    chk("tmo_flag_set", cal_timeout, 1'b1);

    // successful calibration clears the flag
    model_en = 1'b1;
    @(posedge USER_CLK); #1 cal_req = 1'b1;
    wait_for(2, 2000, "recal_cal_ack");
    cal_req = 1'b0;
    chk("recal_flag_clear", cal_timeout, 1'b0);

    // reset in the middle of a host frame
    exp_q.push_back(32'h001C0F0F);
    @(posedge USER_CLK); #1;
    cfg_addr = 4'hC; cfg_data = 16'h0F0F; cfg_req = 1'b1;
    n = 0;
    while (!(in_fr && nbits >= 15) && n < 2000) begin @(negedge USER_CLK); n++; end
    chk("midrst_in_frame", ADC_SCS, 1'b0);
    @(posedge USER_CLK); #3 USER_RESET_N = 1'b0;
    #1;
    chk("midrst_scs", ADC_SCS, 1'b1);
    chk("midrst_sclk", ADC_SCLK, 1'b0);
    chk("midrst_sdata", ADC_SDATA, 1'b0);
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_busy", busy, 1'b1);
    cfg_req = 1'b0;
    exp_q.delete();
    push_init();
    repeat (3) @(posedge USER_CLK); #1 USER_RESET_N = 1'b1;
    wait_for(0, 10000, "replay_ready");
    chk("replay_frames_left", exp_q.size(), 0);
    chk("replay_cal_timeout", cal_timeout, 1'b0);

`ifdef ADC_CFG_SHADOW_EN
    host_write(4'h5, 16'hBEEF, "shadow_cfg_ack");
    repeat (2) @(posedge USER_CLK); #1 shadow_addr = 4'h5;
    @(posedge USER_CLK); #1;
    chk("shadow_5", shadow_data, 16'hBEEF);
    shadow_addr = 4'h1;
    @(posedge USER_CLK); #1;
    chk("shadow_1", shadow_data, 16'hB2FF);
`endif

    repeat (20) @(negedge USER_CLK);
    chk("final_frames_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_cfg_ctrl.md
Name: adc_cfg_ctrl

Overview:
Sequences the ADC's 3-wire serial configuration port and calibration pins. After reset it waits out ADC power-up, writes a fixed init register table and runs one calibration, then asserts ready. After that it serves single-register writes and calibration requests from the UART command decoder over a req/ack handshake. It sits in DataAcqTop between the command decoder and the ADC_SCLK/ADC_SDATA/ADC_SCS/ADC_RUN_CALIB/ADC_CALIB pins, in the USER_CLK domain.

Parameters:
SCLK_DIV, 4, USER_CLK cycles per SCLK half-period (minimum 2)
POR_CYCLES, 4000, power-up wait after reset release
GAP_CYCLES, 8, minimum ADC_SCS-high time between frames
CAL_PULSE_CYCLES, 40, ADC_RUN_CALIB high width
CAL_TIMEOUT, 1048576, maximum wait for calibration to complete
NUM_INIT, 3, number of init table entries

Ports:
USER_CLK  in  1  system clock
USER_RESET_N  in  1  asynchronous active-low reset
cfg_req  in  1  register write request; held until cfg_ack
cfg_addr  in  4  register address
cfg_data  in  16  register value
cfg_ack  out  1  one-cycle pulse when the write frame completes
cal_req  in  1  calibration request; held until cal_ack
cal_ack  out  1  one-cycle pulse when calibration ends or times out
busy  out  1  high whenever the state is not IDLE
ready  out  1  high once the init sequence has finished
cal_timeout  out  1  sticky flag: last calibration timed out
ADC_SCLK  out  1  serial clock
ADC_SDATA  out  1  serial data, MSB first
ADC_SCS  out  1  chip select, active low
ADC_RUN_CALIB  out  1  calibration start
ADC_CALIB  in  1  ADC reports calibration in progress (high)

Behaviour:
- Async reset values: ADC_SCS=1, ADC_SCLK=0, ADC_SDATA=0, ADC_RUN_CALIB=0, cfg_ack=0, cal_ack=0, ready=0, cal_timeout=0, busy=1, state=POR_WAIT. All outputs are registered.
- ADC_CALIB passes through a 2-flop synchroniser before any use.
- Frame is 32 bits: {12'h001 header, addr[3:0], data[15:0]}, MSB first.
- Frame timing:
  - ADC_SCS falls with bit31 already on ADC_SDATA.
  - SCLK is low for SCLK_DIV cycles, then high for SCLK_DIV cycles, repeated 32 times.
  - SDATA updates only on the cycle SCLK falls, so it is stable at every rising edge.
  - ADC_SCS stays low for exactly 64*SCLK_DIV cycles (256 at default), then rises in the same cycle SCLK returns low.
  - ADC_SDATA goes to 0 after the frame.
- States:
  - POR_WAIT: count POR_CYCLES, then go to INIT.
  - INIT: load init table entry i, go to SHIFT.
  - SHIFT: shift the frame out, go to GAP.
  - GAP: hold SCS high for GAP_CYCLES. Then:
    - during init, i+1 < NUM_INIT: return to INIT;
    - during init, last entry: go to CAL_PULSE;
    - otherwise: pulse cfg_ack in the last GAP cycle and go to IDLE.
  - CAL_PULSE: hold ADC_RUN_CALIB high for CAL_PULSE_CYCLES, go to CAL_WAIT.
  - CAL_WAIT: wait for synchronised ADC_CALIB to rise then fall.
    - On the fall: clear cal_timeout.
    - If CAL_TIMEOUT cycles elapse first (counted from CAL_WAIT entry): set cal_timeout.
    - Either way, exit to IDLE. A host-requested calibration also pulses cal_ack on exit.
    - At the end of the init calibration, ready goes to 1 and stays there until reset.
  - IDLE: busy=0. cfg_req takes priority: latch addr/data and go to SHIFT. Else cal_req goes to CAL_PULSE.
- Requests outside IDLE are not lost; they stay pending because the requester holds them.
- The requester drops req in the cycle after ack. If req is still high in the cycle after ack, it is accepted again.
- If cfg_addr/cfg_data change during a frame, there is no effect; they are latched at acceptance.
- Reset mid-frame: outputs return to their reset values immediately and the sequence restarts from POR_WAIT.

Optional Feature:
ADC_CFG_SHADOW_EN
- Defined: adds ports shadow_addr in 4 and shadow_data out 16, plus a 16x16 shadow register file.
  - Written with the frame's addr/data when the frame completes, for both init and host frames.
  - shadow_data is registered with 1-cycle read latency.
  - All entries reset to 0.
- Undefined: no shadow ports and no storage.

Decomposition:
- Package adc_cfg_pkg:
  - state encoding;
  - FRAME_HEADER = 12'h001;
  - init table as constant arrays of address and value, default entries {4'h1:16'hB2FF, 4'h2:16'h007F, 4'h3:16'h8000};
  - frame width constant 32.
- One sub-module, adc_serial_shifter: SCLK divider, 32-bit shift register and SCS generation.
  - Interface: start, frame[31:0], done pulse.
  - The controller FSM drives it.

Test Plan:
- Reset release, ADC model pulses ADC_CALIB high for 200 cycles after ADC_RUN_CALIB → 3 frames decoded 0x001_1_B2FF, 0x001_2_007F, 0x001_3_8000; ready=1 after CAL_WAIT; cal_timeout=0.
- After ready, cfg_req with addr=4'hA, data=16'h1234 → one frame 0x001A1234; ADC_SCS low exactly 256 cycles; cfg_ack single pulse; busy back to 0.
- cfg_req and cal_req asserted in the same IDLE cycle → cfg frame first with cfg_ack, then ADC_RUN_CALIB high 40 cycles, then cal_ack.
- cal_req with ADC_CALIB held at 0 → cal_ack after 1048576 cycles in CAL_WAIT; cal_timeout=1; next successful calibration clears it.
- USER_RESET_N pulsed low at bit 17 of a host frame → ADC_SCS=1, SCLK=0 asynchronously; full init sequence replays.
- With ADC_CFG_SHADOW_EN: write addr 4'h5 = 16'hBEEF, then shadow_addr=5 → shadow_data=16'hBEEF one cycle later; shadow_addr=1 → 16'hB2FF.
